// File: rtl/calendar_pkg.sv
// Shared constants and types for the timestamp line formatter.
//   MSG_LEN_*  : line lengths with / without trailing CR LF
//   IDX_W      : character index width, sized for the longest line
//   state_t    : formatter FSM states
//   ts_snap_t  : BCD snapshot of the calendar fields taken at send
//   bcd_ascii  : BCD digit to ASCII, non-decimal nibbles become '?'
package calendar_pkg;
  localparam int MSG_LEN_CRLF   = 21;
  localparam int MSG_LEN_NOCRLF = 19;
  localparam int IDX_W          = $clog2(MSG_LEN_CRLF);

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_QM    = 8'h3F;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  min;
    logic [7:0]  sec;
  } ts_snap_t;

  function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_QM : (ASCII_0 + {4'd0, d});
  endfunction
endpackage

// File: rtl/timestamp_uart_fmt_if.sv
// Request / UART-side bundle of the timestamp formatter.
//   send, *_bcd : line request and calendar fields (master -> slave)
//   tx_busy     : downstream UART busy flag (master -> slave)
//   tx_en/data  : byte strobe and byte (slave -> master)
//   busy, done  : formatter status (slave -> master)
interface timestamp_uart_fmt_if;
  logic        send;
  logic [15:0] year_bcd;
  logic [7:0]  month_bcd;
  logic [7:0]  day_bcd;
  logic [7:0]  hour_bcd;
  logic [7:0]  min_bcd;
  logic [7:0]  sec_bcd;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;

  modport master (
    output send, year_bcd, month_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd, tx_busy,
    input  tx_en, tx_data, busy, done
  );
  modport slave (
    input  send, year_bcd, month_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd, tx_busy,
    output tx_en, tx_data, busy, done
  );
endinterface

// File: rtl/ts_char_sel.sv
// Combinational character selector: maps a line position and the
// snapshot to the ASCII byte "YYYY-MM-DD HH:MM:SS\r\n".
//   idx  : character position
//   snap : captured calendar fields
//   ch   : ASCII byte at idx
module ts_char_sel
  import calendar_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  ts_snap_t         snap,
  output logic [7:0]       ch
);
  always_comb begin
    ch = 8'h00;
    case (idx)
      5'd0:  ch = bcd_ascii(snap.year[15:12]);
      5'd1:  ch = bcd_ascii(snap.year[11:8]);
      5'd2:  ch = bcd_ascii(snap.year[7:4]);
      5'd3:  ch = bcd_ascii(snap.year[3:0]);
      5'd4:  ch = ASCII_DASH;
      5'd5:  ch = bcd_ascii(snap.month[7:4]);
      5'd6:  ch = bcd_ascii(snap.month[3:0]);
      5'd7:  ch = ASCII_DASH;
      5'd8:  ch = bcd_ascii(snap.day[7:4]);
      5'd9:  ch = bcd_ascii(snap.day[3:0]);
      5'd10: ch = ASCII_SP;
      5'd11: ch = bcd_ascii(snap.hour[7:4]);
      5'd12: ch = bcd_ascii(snap.hour[3:0]);
      5'd13: ch = ASCII_COLON;
      5'd14: ch = bcd_ascii(snap.min[7:4]);
      5'd15: ch = bcd_ascii(snap.min[3:0]);
      5'd16: ch = ASCII_COLON;
      5'd17: ch = bcd_ascii(snap.sec[7:4]);
      5'd18: ch = bcd_ascii(snap.sec[3:0]);
      5'd19: ch = ASCII_CR;
      5'd20: ch = ASCII_LF;
      default: ch = 8'h00;
    endcase
  end
endmodule

// File: rtl/timestamp_uart_fmt.sv
// Timestamp line formatter: on send, snapshots the BCD calendar and
// streams it byte by byte into a UART transmitter using its busy flag
// as the handshake (wait for busy to rise, then fall, per byte).
//   clk, reset : clock, async active-high reset
//   bus        : slave side of timestamp_uart_fmt_if
//   CRLF_EN    : 1 -> 21-char line with CR LF, 0 -> 19 chars
module timestamp_uart_fmt
  import calendar_pkg::*;
#(
  parameter int CRLF_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  timestamp_uart_fmt_if.slave bus
);
  localparam int               MSG_LEN  = (CRLF_EN != 0) ? MSG_LEN_CRLF : MSG_LEN_NOCRLF;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  ts_snap_t         snap, snap_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             done_q, done_d;
  logic [7:0]       ch;

  ts_char_sel u_sel (.idx(idx), .snap(snap), .ch(ch));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      snap      <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      snap      <= snap_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

  // tx_en and done default low so each is a single-cycle pulse;
  // tx_data holds until the next ISSUE load.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    snap_d    = snap;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    case (state)
      IDLE: if (bus.send) begin
        snap_d  = '{bus.year_bcd, bus.month_bcd, bus.day_bcd,
                    bus.hour_bcd, bus.min_bcd, bus.sec_bcd};
        idx_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: if (!bus.tx_busy) begin
        tx_en_d   = 1'b1;
        tx_data_d = ch;
        state_d   = WAIT_HI;
      end
      // The UART must acknowledge by raising busy; no timeout here.
      WAIT_HI: if (bus.tx_busy) state_d = WAIT_LO;
      WAIT_LO: if (!bus.tx_busy) begin
        if (idx == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx + IDX_W'(1);
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_en   = tx_en_q;
  assign bus.tx_data = tx_data_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state != IDLE);
endmodule

// File: doc/timestamp_uart_fmt.md
TIMESTAMP_UART_FMT -- requirements
Module: timestamp_uart_fmt

Interface
REQ-001 SHALL have parameter CRLF_EN, default 1, meaning: 1 appends CR LF, giving 21 chars; 0 omits them, giving 19 chars.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock, all state on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port send, input, 1 bit: request to emit one timestamp line.
REQ-005 SHALL have port year_bcd, input, 16 bits: four BCD digits, MSD in [15:12].
REQ-006 SHALL have ports month_bcd, day_bcd, hour_bcd, min_bcd and sec_bcd, each input, 8 bits: two BCD digits, tens digit in [7:4].
REQ-007 SHALL have port tx_busy, input, 1 bit: the busy flag from the downstream UART transmitter.
REQ-008 SHALL have port tx_en, output, 1 bit: one-cycle byte-send strobe to the transmitter.
REQ-009 SHALL have port tx_data, output, 8 bits: the ASCII byte, valid whenever tx_en=1.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the last byte finishes.

Function
REQ-012 SHALL emit "YYYY-MM-DD HH:MM:SS" followed by 0x0D 0x0A when CRLF_EN=1; char index 0..MSG_LEN-1.
REQ-013 SHALL map each digit to ASCII as 0x30+nibble; a nibble >9 SHALL map to 0x3F ('?').
REQ-014 SHALL use separators '-' (0x2D) at idx 4 and 7, ' ' (0x20) at idx 10, and ':' (0x3A) at idx 13 and 16.
REQ-015 SHALL have exactly four FSM states: IDLE, ISSUE, WAIT_HI and WAIT_LO.
REQ-016 In IDLE, send=1 SHALL latch all BCD inputs into a snapshot, clear idx to 0, and go to ISSUE.
REQ-017 A send in any other state SHALL be ignored, with no queuing.
REQ-018 In ISSUE with tx_busy=0, the block SHALL register tx_en=1 and tx_data=char[idx] and go to WAIT_HI; with tx_busy=1 it SHALL stay in ISSUE.
REQ-019 tx_en SHALL be high for exactly one cycle per byte.
REQ-020 WAIT_HI SHALL force tx_en=0 and go to WAIT_LO only when tx_busy=1; it SHALL NOT time out.
REQ-021 In WAIT_LO with tx_busy=0: if idx=MSG_LEN-1, the block SHALL pulse done and go to IDLE; otherwise it SHALL increment idx and go to ISSUE.
REQ-022 Latency: send sampled at edge k SHALL give tx_en=1 in the cycle following edge k+1, carrying the first byte.
REQ-023 tx_data SHALL hold its value until the next ISSUE load.
REQ-024 Input changes after the snapshot SHALL NOT affect the line in flight.
REQ-025 idx SHALL be width $clog2(21) and SHALL never exceed MSG_LEN-1.
REQ-026 done and a new send in the same cycle: done SHALL assert, the block SHALL return to IDLE, and that send SHALL be ignored.

Reset
REQ-027 reset SHALL immediately force: state=IDLE, tx_en=0, tx_data=0x00, busy=0, done=0, idx=0, snapshot=0.
REQ-028 Reset during a line SHALL abort it with no further tx_en; the next send after release SHALL restart at idx 0.

Structure
REQ-029 ASCII constants, MSG_LEN_CRLF=21, MSG_LEN_NOCRLF=19 and the state encodings SHALL reside in the shared package calendar_pkg.
REQ-030 The combinational mapping from idx and snapshot to byte SHALL be the sub-module ts_char_sel.
REQ-031 The FSM, idx counter and output registers SHALL reside in the top module.

Verification
REQ-032 Year 0x2024, month 0x03, day 0x15, hour 0x09, min 0x07, sec 0x59, send pulse, behavioral UART model -> bytes "2024-03-15 09:07:59" 0D 0A in order, 21 tx_en pulses, one done.
REQ-033 CRLF_EN=0, same inputs -> 19 bytes, ending with 0x39, then done.
REQ-034 hour_bcd=0xA5 -> byte idx 11 = 0x3F and idx 12 = 0x35.
REQ-035 Hold tx_busy=1 for 500 cycles at start -> no tx_en while busy; first tx_en 1 cycle after tx_busy falls.
REQ-036 Assert send again at byte 5 and change sec_bcd mid-line -> output unchanged, still one done.
REQ-037 Assert reset at byte 8 -> tx_en=0 and busy=0 immediately; a fresh send then yields a full 21-byte line.
